interval_timer: RTL and testbench

Parametrised minutes:seconds interval timer for the board-level timer design: counts down from a switch-entered preset, or up from 00:00 to that preset in stopwatch mode. Runs from the board clock through an internal tick divider and raises a blinking alarm on expiry. Outputs are BCD digits ready for the seven-segment decoders, plus status lines for the LEDs.

---
 rtl/interval_timer_if.sv | 31 +++
 rtl/interval_timer.sv | 204 ++++++++++++++++++++
 tb/tb_interval_timer.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/interval_timer_if.sv
// interval_timer_if: control and display bundle for the interval timer.
//   set_btn, toggle_btn : one-cycle pulses, debounced and edge-detected upstream
//   count_up            : 0 = countdown, 1 = stopwatch
//   sw                  : binary value entry, clamped to 59 by the timer
//   min_bcd, sec_bcd    : BCD digits, [7:4] tens, [3:0] ones
//   running, expired    : status lines for the LEDs
//   blink               : alarm flasher while expired
//   tick                : one-cycle pulse on each time-value update
// The master drives the controls; the slave (the timer) drives the display and status.
interface interval_timer_if;
    logic       set_btn;
    logic       toggle_btn;
    logic       count_up;
    logic [7:0] sw;
    logic [7:0] min_bcd;
    logic [7:0] sec_bcd;
    logic       running;
    logic       expired;
    logic       blink;
    logic       tick;

    modport master (
        output set_btn, toggle_btn, count_up, sw,
        input  min_bcd, sec_bcd, running, expired, blink, tick
    );

    modport slave (
        input  set_btn, toggle_btn, count_up, sw,
        output min_bcd, sec_bcd, running, expired, blink, tick
    );
endinterface

// File: rtl/interval_timer.sv
// interval_timer: minutes:seconds countdown / stopwatch with a switch-entered preset.
//   CLOCK_50 : board clock, all state updates on the rising edge
//   reset    : asynchronous, active-low
//   bus      : interval_timer_if.slave (controls in, BCD display and status out)
// A divider of CLK_HZ/TICK_HZ cycles paces the time updates; every output is registered.
module interval_timer #(
    parameter int unsigned CLK_HZ  = 50_000_000,
    parameter int unsigned TICK_HZ = 1
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    interval_timer_if.slave bus
);
    localparam int unsigned Div  = CLK_HZ / TICK_HZ;
    localparam int unsigned DivW = (Div > 1) ? $clog2(Div) : 1;
    localparam logic [DivW-1:0] DivMax = DivW'(Div - 1);

    typedef enum logic [2:0] {
        StIdle, StSetSec, StSetMin, StRunning, StPaused, StExpired
    } state_e;

    state_e          state_q;
    logic [15:0]     preset_q;   // {mm, ss} in BCD
    logic [15:0]     disp_q;     // {mm, ss} in BCD
    logic [DivW-1:0] div_q;
    logic            mode_up_q;
    logic            running_q;
    logic            expired_q;
    logic            blink_q;
    logic            tick_q;

    // Switch value clamped to 0..59 and converted to BCD.
    logic [5:0] sw_clamped;
    logic [3:0] sw_tens;
    logic [3:0] tens_x10_lo;  // low nibble of 10*tens; the ones digit fits in 4 bits
    logic [7:0] sw_bcd;

    assign sw_clamped = (bus.sw > 8'd59) ? 6'd59 : bus.sw[5:0];

    always_comb begin
        sw_tens     = 4'd0;
        tens_x10_lo = 4'd0;
        if (sw_clamped >= 6'd50) begin
            sw_tens = 4'd5; tens_x10_lo = 4'd2;
        end else if (sw_clamped >= 6'd40) begin
            sw_tens = 4'd4; tens_x10_lo = 4'd8;
        end else if (sw_clamped >= 6'd30) begin
            sw_tens = 4'd3; tens_x10_lo = 4'd14;
        end else if (sw_clamped >= 6'd20) begin
            sw_tens = 4'd2; tens_x10_lo = 4'd4;
        end else if (sw_clamped >= 6'd10) begin
            sw_tens = 4'd1; tens_x10_lo = 4'd10;
        end
    end

    assign sw_bcd = {sw_tens, sw_clamped[3:0] - tens_x10_lo};

    // BCD decrement with borrow; never applied to 00:00.
    logic [15:0] down_val;
    always_comb begin
        down_val = disp_q;
        if (disp_q[3:0] != 4'd0) begin
            down_val[3:0] = disp_q[3:0] - 4'd1;
        end else if (disp_q[7:4] != 4'd0) begin
            down_val[7:0] = {disp_q[7:4] - 4'd1, 4'd9};
        end else begin
            down_val[7:0] = 8'h59;
            if (disp_q[11:8] != 4'd0) begin
                down_val[11:8] = disp_q[11:8] - 4'd1;
            end else begin
                down_val[15:8] = {disp_q[15:12] - 4'd1, 4'd9};
            end
        end
    end

    // BCD increment with carry; expiry stops it at 59:59 at the latest.
    logic [15:0] up_val;
    always_comb begin
        up_val = disp_q;
        if (disp_q[3:0] != 4'd9) begin
            up_val[3:0] = disp_q[3:0] + 4'd1;
        end else if (disp_q[7:4] != 4'd5) begin
            up_val[7:0] = {disp_q[7:4] + 4'd1, 4'd0};
        end else begin
            up_val[7:0] = 8'h00;
            if (disp_q[11:8] != 4'd9) begin
                up_val[11:8] = disp_q[11:8] + 4'd1;
            end else begin
                up_val[15:8] = {disp_q[15:12] + 4'd1, 4'd0};
            end
        end
    end

    logic up_done;
    logic down_done;
    logic wrap;
    assign up_done   = (preset_q == 16'h0000) ? (up_val == 16'h5959) : (up_val == preset_q);
    assign down_done = (down_val == 16'h0000);
    assign wrap      = (div_q == DivMax);

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            preset_q  <= 16'h0000;
            disp_q    <= 16'h0000;
            div_q     <= '0;
            mode_up_q <= 1'b0;
            running_q <= 1'b0;
            expired_q <= 1'b0;
            blink_q   <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (bus.set_btn) begin
                        state_q <= StSetSec;
                    end else if (bus.toggle_btn) begin
                        if (bus.count_up) begin
                            mode_up_q <= 1'b1;
                            disp_q    <= 16'h0000;
                            div_q     <= '0;
                            running_q <= 1'b1;
                            state_q   <= StRunning;
                        end else if (preset_q != 16'h0000) begin
                            mode_up_q <= 1'b0;
                            disp_q    <= preset_q;
                            div_q     <= '0;
                            running_q <= 1'b1;
                            state_q   <= StRunning;
                        end
                    end
                end
                StSetSec: begin
                    disp_q <= {preset_q[15:8], sw_bcd};
                    if (bus.set_btn) begin
                        preset_q[7:0] <= sw_bcd;
                        state_q       <= StSetMin;
                    end
                end
                StSetMin: begin
                    disp_q <= {sw_bcd, preset_q[7:0]};
                    if (bus.set_btn) begin
                        preset_q[15:8] <= sw_bcd;
                        state_q        <= StIdle;
                    end
                end
                StRunning: begin
                    if (bus.set_btn) begin
                        disp_q    <= preset_q;
                        running_q <= 1'b0;
                        state_q   <= StIdle;
                    end else if (bus.toggle_btn) begin
                        // Divider holds so the resumed interval picks up where it stopped.
                        running_q <= 1'b0;
                        state_q   <= StPaused;
                    end else if (wrap) begin
                        div_q  <= '0;
                        tick_q <= 1'b1;
                        disp_q <= mode_up_q ? up_val : down_val;
                        if (mode_up_q ? up_done : down_done) begin
                            running_q <= 1'b0;
                            expired_q <= 1'b1;
                            state_q   <= StExpired;
                        end
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end
                StPaused: begin
                    if (bus.set_btn) begin
                        disp_q  <= preset_q;
                        state_q <= StIdle;
                    end else if (bus.toggle_btn) begin
                        running_q <= 1'b1;
                        state_q   <= StRunning;
                    end
                end
                StExpired: begin
                    if (bus.set_btn) begin
                        disp_q    <= preset_q;
                        expired_q <= 1'b0;
                        blink_q   <= 1'b0;
                        state_q   <= StIdle;
                    end else if (wrap) begin
                        div_q   <= '0;
                        tick_q  <= 1'b1;
                        blink_q <= ~blink_q;
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.min_bcd = disp_q[15:8];
    assign bus.sec_bcd = disp_q[7:0];
    assign bus.running = running_q;
    assign bus.expired = expired_q;
    assign bus.blink   = blink_q;
    assign bus.tick    = tick_q;
endmodule

// File: tb/tb_interval_timer.sv
// tb_interval_timer: directed vector table plus hand-written multi-cycle sequences
// for the interval timer at CLK_HZ=10, TICK_HZ=1 (ten cycles per update).
module tb_interval_timer;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    interval_timer_if bus ();

    interval_timer #(
        .CLK_HZ  (10),
        .TICK_HZ (1)
    ) dut (
        .CLOCK_50 (clk),
        .reset    (rst_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       set;
        logic       tog;
        logic       cup;
        logic [7:0] sw;
        int         idle;    // extra cycles after the pulse cycle before checking
        logic [7:0] emin;
        logic [7:0] esec;
        logic       erun;
        logic       eexp;
        logic       eblink;
        logic       etick;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_disp(input string name, input logic [15:0] exp);
        check(name, {bus.min_bcd, bus.sec_bcd}, {16'h0, exp});
    endtask

    // All tasks start and end on a falling edge.
    task automatic pulse_set();
        bus.set_btn = 1'b1;
        @(negedge clk);
        bus.set_btn = 1'b0;
    endtask

    task automatic pulse_toggle();
        bus.toggle_btn = 1'b1;
        @(negedge clk);
        bus.toggle_btn = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic set_preset(input logic [7:0] m, input logic [7:0] s);
        bus.sw = s;
        pulse_set();
        pulse_set();
        bus.sw = m;
        pulse_set();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    int changed;
    int ticks_seen;

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        bus.set_btn    = 1'b0;
        bus.toggle_btn = 1'b0;
        bus.count_up   = 1'b0;
        bus.sw         = 8'd0;

        //            set  tog  cup  sw     idle emin   esec   run  exp  blk  tck
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'd75, 1,   8'h00, 8'h59, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 8'd75, 0,   8'h00, 8'h59, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 8'd2,  0,   8'h02, 8'h59, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 8'd2,  0,   8'h02, 8'h59, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 8'd2,  0,   8'h02, 8'h59, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 8'd30, 1,   8'h02, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 8'd30, 0,   8'h02, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 8'd0,  0,   8'h02, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 8'd1,  0,   8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 8'd1,  9,   8'h01, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 8'd1,  0,   8'h00, 8'h59, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 8'd1,  9,   8'h00, 8'h58, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 8'd1,  579, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 8'd1,  8,   8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 8'd1,  0,   8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[15] = '{1'b1, 1'b1, 1'b0, 8'd1,  0,   8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};

        // Reset state while reset is held.
        @(negedge clk);
        check_disp("reset_disp", 16'h0000);
        check("reset_status", {bus.running, bus.expired, bus.blink, bus.tick}, 4'b0000);
        rst_n = 1'b1;

        // Entry, clamping, ignored toggles, countdown borrow, expiry and blink.
        for (int i = 0; i < 16; i++) begin
            bus.set_btn    = vecs[i].set;
            bus.toggle_btn = vecs[i].tog;
            bus.count_up   = vecs[i].cup;
            bus.sw         = vecs[i].sw;
            @(negedge clk);
            bus.set_btn    = 1'b0;
            bus.toggle_btn = 1'b0;
            repeat (vecs[i].idle) @(negedge clk);
            check_disp($sformatf("vec%0d_disp", i), {vecs[i].emin, vecs[i].esec});
            check($sformatf("vec%0d_status", i),
                  {bus.running, bus.expired, bus.blink, bus.tick},
                  {vecs[i].erun, vecs[i].eexp, vecs[i].eblink, vecs[i].etick});
        end

        // Pause at divider=4 for 37 cycles; next update 6 cycles after resume.
        do_reset();
        bus.count_up = 1'b0;
        set_preset(8'd0, 8'd5);
        pulse_toggle();
        repeat (4) @(negedge clk);
        pulse_toggle();
        check("pause_running", {31'h0, bus.running}, 32'h0);
        changed    = 0;
        ticks_seen = 0;
        repeat (37) begin
            @(negedge clk);
            if ({bus.min_bcd, bus.sec_bcd} != 16'h0005) changed++;
            if (bus.tick) ticks_seen++;
        end
        check("pause_frozen", changed + ticks_seen, 0);
        pulse_toggle();
        repeat (5) @(negedge clk);
        check("resume_pre_disp", {bus.min_bcd, bus.sec_bcd, 7'h0, bus.tick, 7'h0, bus.running},
              {16'h0005, 8'h00, 8'h01});
        @(negedge clk);
        check("resume_update", {bus.min_bcd, bus.sec_bcd, 7'h0, bus.tick, 7'h0, bus.running},
              {16'h0004, 8'h01, 8'h01});
        // set and toggle together while running: set wins.
        bus.set_btn    = 1'b1;
        bus.toggle_btn = 1'b1;
        @(negedge clk);
        bus.set_btn    = 1'b0;
        bus.toggle_btn = 1'b0;
        check_disp("collide_disp", 16'h0005);
        check("collide_status", {bus.running, bus.expired, bus.blink, bus.tick}, 4'b0000);

        // Stopwatch to preset 00:03, mode flipped mid-run.
        do_reset();
        set_preset(8'd0, 8'd3);
        bus.count_up = 1'b1;
        pulse_toggle();
        check_disp("sw_start", 16'h0000);
        repeat (10) @(negedge clk);
        check_disp("sw_1", 16'h0001);
        bus.count_up = 1'b0;
        repeat (10) @(negedge clk);
        check_disp("sw_2", 16'h0002);
        check("sw_2_status", {bus.running, bus.expired}, 2'b10);
        repeat (10) @(negedge clk);
        check_disp("sw_3", 16'h0003);
        check("sw_3_status", {bus.running, bus.expired, bus.tick}, 3'b011);
        pulse_set();
        check_disp("sw_exit_disp", 16'h0003);
        check("sw_exit_status", {bus.running, bus.expired, bus.blink}, 3'b000);

        // Countdown toggle with preset 00:00 stays idle.
        do_reset();
        bus.count_up = 1'b0;
        pulse_toggle();
        ticks_seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.tick || bus.running) ticks_seen++;
        end
        check("zero_guard", ticks_seen, 0);
        check_disp("zero_guard_disp", 16'h0000);

        // Asynchronous reset between clock edges while running.
        do_reset();
        set_preset(8'd0, 8'd5);
        pulse_toggle();
        repeat (9) @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_all",
              {bus.min_bcd, bus.sec_bcd, bus.running, bus.expired, bus.blink, bus.tick},
              {16'h0000, 4'b0000});
        @(negedge clk);
        rst_n = 1'b1;
        ticks_seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.tick || bus.running) ticks_seen++;
        end
        check("post_reset_quiet", ticks_seen, 0);
        check_disp("post_reset_disp", 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
